// File: rtl/sccb_init_seq.sv
// rtl/sccb_init_seq.sv - camera register-init sequencer driving the SCCB bridge command bus
// Optional readback verify of every write is enabled by defining SCCB_VERIFY_EN.
module sccb_init_seq #(
    parameter logic [6:0]  DEV_ID     = 7'h21,
    parameter int          TBL_AW     = 8,
    parameter logic [15:0] DELAY_UNIT = 16'd1000,
    parameter logic [19:0] TIMEOUT    = 20'hFFFFF
) (
    input  logic              sccb_clk,
    input  logic              sccb_reset,
    input  logic              start,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [17:0]       tbl_data,
    output logic [2:0]        mcmd,
    output logic [14:0]       maddr,
    output logic [7:0]        mdata,
    input  logic              scmdaccept,
    input  logic [1:0]        sresp,
    input  logic [7:0]        sdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [TBL_AW-1:0] err_idx,
    output logic [TBL_AW-1:0] wr_count
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_DELAY, S_ISSUE, S_WAIT_DONE,
`ifdef SCCB_VERIFY_EN
        S_V_ISSUE, S_V_WAIT,
`endif
        S_DONE, S_ERROR
    } state_t;

    localparam logic [TBL_AW-1:0] IDX_ONE  = TBL_AW'(1);
    localparam logic [19:0]       TMO_LAST = TIMEOUT - 20'd1;

    state_t       state, state_n;
    logic [19:0]  tmo_cnt;
    logic [23:0]  dly_cnt;
    logic         advance, wr_inc, err_hit, run_start, last_entry;
    logic [1:0]   op;
    logic [7:0]   reg_a, val_b;

    assign op         = tbl_data[17:16];
    assign reg_a      = tbl_data[15:8];
    assign val_b      = tbl_data[7:0];
    assign last_entry = &tbl_addr;
    assign busy       = !(state == S_IDLE || state == S_DONE || state == S_ERROR);
    assign run_start  = !busy && start;

`ifdef SCCB_VERIFY_EN
    logic       got_dva, rd_ok;
    logic [7:0] rd_byte, rd_val;

    // DVA may land on the same cycle the bridge re-idles, so look at it combinationally too
    assign rd_ok  = got_dva || (sresp == 2'b01);
    assign rd_val = (sresp == 2'b01) ? sdata : rd_byte;

    always_ff @(posedge sccb_clk) begin
        if (sccb_reset) begin
            got_dva <= 1'b0;
            rd_byte <= '0;
        end else if (state == S_V_ISSUE) begin
            got_dva <= 1'b0;
        end else if (state == S_V_WAIT && sresp == 2'b01) begin
            got_dva <= 1'b1;
            rd_byte <= sdata;
        end
    end
`else
    logic unused_rd;
    assign unused_rd = ^{sresp, sdata};
`endif

    always_comb begin
        state_n = state;
        advance = 1'b0;
        wr_inc  = 1'b0;
        err_hit = 1'b0;
        mcmd    = 3'b000;
        case (state)
            S_IDLE, S_DONE, S_ERROR: if (start) state_n = S_FETCH;
            S_FETCH:  state_n = S_DECODE;
            S_DECODE: begin
                case (op)
                    2'b00:   state_n = S_ISSUE;
                    2'b01:   if (val_b != 8'd0) state_n = S_DELAY; else advance = 1'b1;
                    2'b10:   advance = 1'b1;
                    default: state_n = S_DONE;
                endcase
            end
            S_DELAY:  if (dly_cnt == 24'd0) advance = 1'b1;
            S_ISSUE: begin
                mcmd = 3'b001;
                if (!scmdaccept) state_n = S_WAIT_DONE;
                else if (tmo_cnt == TMO_LAST) err_hit = 1'b1;
            end
            S_WAIT_DONE: begin
                if (scmdaccept) begin
`ifdef SCCB_VERIFY_EN
                    state_n = S_V_ISSUE;
`else
                    wr_inc  = 1'b1;
                    advance = 1'b1;
`endif
                end else if (tmo_cnt == TMO_LAST) err_hit = 1'b1;
            end
`ifdef SCCB_VERIFY_EN
            S_V_ISSUE: begin
                mcmd = 3'b010;
                if (!scmdaccept) state_n = S_V_WAIT;
                else if (tmo_cnt == TMO_LAST) err_hit = 1'b1;
            end
            S_V_WAIT: begin
                if (scmdaccept) begin
                    if (rd_ok && rd_val == mdata) begin
                        wr_inc  = 1'b1;
                        advance = 1'b1;
                    end else err_hit = 1'b1;
                end else if (tmo_cnt == TMO_LAST) err_hit = 1'b1;
            end
`endif
            default: state_n = S_IDLE;
        endcase
        if (advance) state_n = last_entry ? S_DONE : S_FETCH;
        if (err_hit) state_n = S_ERROR;
    end

    always_ff @(posedge sccb_clk) begin
        if (sccb_reset) begin
            state    <= S_IDLE;
            tbl_addr <= '0;
            maddr    <= '0;
            mdata    <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_idx  <= '0;
            wr_count <= '0;
            tmo_cnt  <= '0;
            dly_cnt  <= '0;
        end else begin
            state   <= state_n;
            // every phase change restarts the handshake timeout
            tmo_cnt <= (state_n != state) ? 20'd0 : tmo_cnt + 20'd1;
            if (run_start) begin
                tbl_addr <= '0;
                done     <= 1'b0;
                error    <= 1'b0;
                wr_count <= '0;
            end
            if (state == S_DECODE) begin
                dly_cnt <= ({16'd0, val_b} * {8'd0, DELAY_UNIT}) - 24'd1;
                if (op == 2'b00) begin
                    maddr <= {DEV_ID, reg_a};
                    mdata <= val_b;
                end
            end else if (state == S_DELAY) begin
                dly_cnt <= dly_cnt - 24'd1;
            end
            if (advance && !last_entry) tbl_addr <= tbl_addr + IDX_ONE;
            if (wr_inc) wr_count <= wr_count + IDX_ONE;
            if (busy && state_n == S_DONE) done <= 1'b1;
            if (err_hit) begin
                error   <= 1'b1;
                err_idx <= tbl_addr;
            end
        end
    end

endmodule

// File: tb/tb_sccb_init_seq.sv
// tb/tb_sccb_init_seq.sv - directed bench for sccb_init_seq with a behavioural SCCB bridge model
module tb_sccb_init_seq;

    localparam int TMO = 200;
`ifdef SCCB_VERIFY_EN
    localparam int VFY = 1;
`else
    localparam int VFY = 0;
`endif
    localparam logic [17:0] END_E = 18'h30000;

    logic        sccb_clk = 1'b0;
    logic        sccb_reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  tbl_addr;
    logic [17:0] tbl_data = '0;
    logic [2:0]  mcmd;
    logic [14:0] maddr;
    logic [7:0]  mdata;
    logic        scmdaccept = 1'b1;
    logic [1:0]  sresp = 2'b00;
    logic [7:0]  sdata = 8'h00;
    logic        busy, done, error;
    logic [7:0]  err_idx, wr_count;

    int n_chk = 0;
    int n_fail = 0;

    logic [17:0] rom [256];
    int          cyc = 0;
    int          n_wr = 0;
    int          n_rd = 0;
    int          wlimit = 1 << 30;
    int          brg_lat = 50;
    bit          bad_rd = 1'b0;
    int          brg_cnt = 0;
    bit          brg_rd = 1'b0;
    logic [7:0]  last_wd = 8'h00;
    logic [14:0] w_addr [1024];
    logic [7:0]  w_data [1024];
    int          w_cyc  [1024];

    sccb_init_seq #(
        .DEV_ID(7'h21), .TBL_AW(8), .DELAY_UNIT(16'd10), .TIMEOUT(20'(TMO))
    ) dut (
        .sccb_clk(sccb_clk), .sccb_reset(sccb_reset), .start(start),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .mcmd(mcmd), .maddr(maddr), .mdata(mdata),
        .scmdaccept(scmdaccept), .sresp(sresp), .sdata(sdata),
        .busy(busy), .done(done), .error(error),
        .err_idx(err_idx), .wr_count(wr_count)
    );

    always #5 sccb_clk = ~sccb_clk;

    always @(posedge sccb_clk) begin
        cyc      <= cyc + 1;
        tbl_data <= rom[tbl_addr];
    end

    // bridge: takes a command while idle, stays busy brg_lat cycles, DVA one cycle before re-idle
    always @(posedge sccb_clk) begin
        sresp <= 2'b00;
        if (brg_cnt != 0) begin
            brg_cnt <= brg_cnt - 1;
            if (brg_cnt == 2 && brg_rd) begin
                sresp <= 2'b01;
                sdata <= bad_rd ? 8'h7F : last_wd;
            end
            if (brg_cnt == 1) scmdaccept <= 1'b1;
        end else if (scmdaccept && mcmd != 3'b000) begin
            if (mcmd == 3'b001 && n_wr < wlimit) begin
                scmdaccept       <= 1'b0;
                brg_cnt          <= brg_lat;
                brg_rd           <= 1'b0;
                last_wd          <= mdata;
                w_addr[n_wr[9:0]] <= maddr;
                w_data[n_wr[9:0]] <= mdata;
                w_cyc[n_wr[9:0]]  <= cyc;
                n_wr             <= n_wr + 1;
            end else if (mcmd == 3'b010) begin
                scmdaccept <= 1'b0;
                brg_cnt    <= brg_lat;
                brg_rd     <= 1'b1;
                n_rd       <= n_rd + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] wr(input logic [7:0] r, input logic [7:0] v);
        return {2'b00, r, v};
    endfunction

    task automatic load_tbl(input logic [17:0] e0, input logic [17:0] e1, input logic [17:0] e2);
        for (int i = 0; i < 256; i++) rom[i] = END_E;
        rom[0] = e0;
        rom[1] = e1;
        rom[2] = e2;
    endtask

    task automatic pulse_start();
        @(negedge sccb_clk);
        start = 1'b1;
        @(negedge sccb_clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int k;
        k = 0;
        while (!(done || error) && k < budget) begin
            @(negedge sccb_clk);
            k++;
        end
        if (!(done || error)) check("wait_end_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_gap(input logic [17:0] e1, output int gap);
        int b;
        load_tbl(wr(8'h12, 8'h80), e1, wr(8'h11, 8'h01));
        if (e1 == END_E) load_tbl(wr(8'h12, 8'h80), wr(8'h11, 8'h01), END_E);
        b = n_wr;
        pulse_start();
        wait_end(3000);
        gap = w_cyc[b + 1] - w_cyc[b];
    endtask

    initial begin
        int b, r, k, cnt, g_a, g_b, g_c, g_d;

        // reset state
        repeat (3) @(negedge sccb_clk);
        check("rst_mcmd", mcmd, 3'b000);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_tbl_addr", tbl_addr, 8'h00);
        check("rst_maddr", maddr, 15'h0000);
        check("rst_mdata", mdata, 8'h00);
        check("rst_err_idx", err_idx, 8'h00);
        check("rst_wr_count", wr_count, 8'h00);
        start = 1'b1;
        @(negedge sccb_clk);
        sccb_reset = 1'b0;
        start = 1'b0;
        check("start_with_reset", busy, 1'b0);
        repeat (2) @(negedge sccb_clk);

        // two writes then END
        load_tbl(wr(8'h12, 8'h80), wr(8'h11, 8'h01), END_E);
        b = n_wr;
        r = n_rd;
        pulse_start();
        wait_end(3000);
        check("t1_n_writes", n_wr - b, 2);
        check("t1_maddr0", w_addr[b], 15'h2112);
        check("t1_mdata0", w_data[b], 8'h80);
        check("t1_maddr1", w_addr[b + 1], 15'h2111);
        check("t1_mdata1", w_data[b + 1], 8'h01);
        check("t1_n_reads", n_rd - r, 2 * VFY);
        check("t1_done", done, 1'b1);
        check("t1_error", error, 1'b0);
        check("t1_wr_count", wr_count, 8'd2);
        check("t1_busy", busy, 1'b0);
        check("t1_mcmd_idle", mcmd, 3'b000);
        check("t1_maddr_hold", maddr, 15'h2111);
        check("t1_mdata_hold", mdata, 8'h01);

        // delay / no-op entries: extra time = fetch+decode (2) + val*DELAY_UNIT
        run_gap(END_E, g_a);
        run_gap({2'b01, 8'h00, 8'h05}, g_b);
        run_gap({2'b01, 8'h00, 8'h00}, g_c);
        run_gap({2'b10, 8'h00, 8'h33}, g_d);
        check("t2_delay5_gap", g_b - g_a, 52);
        check("t2_delay0_gap", g_c - g_a, 2);
        check("t2_noop_gap", g_d - g_a, 2);
        check("t2_noop_wr_count", wr_count, 8'd2);

        // bridge never takes the write: timeout at entry 0
        wlimit = n_wr;
        load_tbl(wr(8'h12, 8'h80), wr(8'h11, 8'h01), END_E);
        pulse_start();
        k = 0;
        cnt = 0;
        while (!error && k < 1000) begin
            if (mcmd == 3'b001) cnt++;
            @(negedge sccb_clk);
            k++;
        end
        check("t3_error", error, 1'b1);
        check("t3_err_idx", err_idx, 8'd0);
        check("t3_mcmd", mcmd, 3'b000);
        check("t3_issue_cycles", cnt, TMO);
        check("t3_done", done, 1'b0);
        check("t3_busy", busy, 1'b0);
        // timeout on the second entry
        wlimit = n_wr + 1;
        pulse_start();
        wait_end(3000);
        check("t3b_error", error, 1'b1);
        check("t3b_err_idx", err_idx, 8'd1);
        check("t3b_wr_count", wr_count, 8'd1);
        wlimit = 1 << 30;
        k = 0;
        while (!scmdaccept && k < 200) begin
            @(negedge sccb_clk);
            k++;
        end

        // reset mid-ISSUE drops mcmd at once
        wlimit = n_wr;
        pulse_start();
        k = 0;
        while (mcmd != 3'b001 && k < 20) begin
            @(negedge sccb_clk);
            k++;
        end
        check("t4_saw_issue", mcmd, 3'b001);
        sccb_reset = 1'b1;
        @(negedge sccb_clk);
        sccb_reset = 1'b0;
        check("t4_issue_rst_mcmd", mcmd, 3'b000);
        wlimit = 1 << 30;

        // reset mid-WAIT_DONE, then restart from entry 0
        b = n_wr;
        pulse_start();
        k = 0;
        while (n_wr == b && k < 100) begin
            @(negedge sccb_clk);
            k++;
        end
        repeat (3) @(negedge sccb_clk);
        sccb_reset = 1'b1;
        @(negedge sccb_clk);
        sccb_reset = 1'b0;
        check("t4_rst_mcmd", mcmd, 3'b000);
        check("t4_rst_busy", busy, 1'b0);
        check("t4_rst_done", done, 1'b0);
        check("t4_rst_tbl_addr", tbl_addr, 8'h00);
        k = 0;
        while (!scmdaccept && k < 200) begin
            @(negedge sccb_clk);
            k++;
        end
        b = n_wr;
        pulse_start();
        check("t4_restart_tbl_addr", tbl_addr, 8'h00);
        check("t4_restart_busy", busy, 1'b1);
        wait_end(3000);
        check("t4_restart_maddr0", w_addr[b], 15'h2112);
        check("t4_restart_wr_count", wr_count, 8'd2);
        check("t4_restart_done", done, 1'b1);

`ifdef SCCB_VERIFY_EN
        // readback mismatch, then clean readback
        bad_rd = 1'b1;
        r = n_rd;
        pulse_start();
        wait_end(3000);
        check("t5_bad_error", error, 1'b1);
        check("t5_bad_err_idx", err_idx, 8'd0);
        check("t5_bad_reads", n_rd - r, 1);
        check("t5_bad_wr_count", wr_count, 8'd0);
        check("t5_bad_done", done, 1'b0);
        bad_rd = 1'b0;
        k = 0;
        while (!scmdaccept && k < 200) begin
            @(negedge sccb_clk);
            k++;
        end
        pulse_start();
        wait_end(3000);
        check("t5_good_done", done, 1'b1);
        check("t5_good_error", error, 1'b0);
        check("t5_good_wr_count", wr_count, 8'd2);
`endif

        // full 256-entry table without END
        brg_lat = 3;
        for (int i = 0; i < 256; i++) rom[i] = {2'b00, i[7:0], ~i[7:0]};
        b = n_wr;
        pulse_start();
        wait_end(20000);
        check("t6_done", done, 1'b1);
        check("t6_error", error, 1'b0);
        check("t6_n_writes", n_wr - b, 256);
        check("t6_wr_count_wrap", wr_count, 8'd0);
        check("t6_first_maddr", w_addr[b], 15'h2100);
        check("t6_first_mdata", w_data[b], 8'hFF);
        check("t6_last_maddr", w_addr[b + 255], 15'h21FF);
        check("t6_last_mdata", w_data[b + 255], 8'h00);
        check("t6_tbl_addr", tbl_addr, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
